// File: rtl/ctrl_pkg.sv
// Shared controller constants: opcode map, FSM state encoding and ACC source codes.
// The datapath imports the same package so that both sides agree on the encodings.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EX_PC  = 3'd3,
    ST_EX_ACC = 3'd4,
    ST_EX_REG = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_MOVR = 4'b0100;
  localparam logic [3:0] OP_MOVA = 4'b0101;
  localparam logic [3:0] OP_JZRS = 4'b0110;
  localparam logic [3:0] OP_JZIM = 4'b0111;
  localparam logic [3:0] OP_JCRS = 4'b1000;
  localparam logic [3:0] OP_JCIM = 4'b1010;
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_LDIM = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] ACC_SRC_ALU = 2'b00;
  localparam logic [1:0] ACC_SRC_REG = 2'b10;
  localparam logic [1:0] ACC_SRC_IMM = 2'b11;

  function automatic logic op_legal(input logic [3:0] o);
    return !((o == 4'b1001) || (o == 4'b1110));
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Counts consecutive FETCH stall cycles; expired fires on the stall cycle that
// brings the count up to limit.
module fetch_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;
  logic [W:0]   cnt_nxt;

  assign cnt_nxt = {1'b0, cnt} + {{W{1'b0}}, 1'b1};
  assign expired = tick && (cnt_nxt >= {1'b0, limit});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clear)            cnt <= '0;
    else if (tick && !expired) cnt <= cnt_nxt[W-1:0];
  end

endmodule

// File: rtl/controller_v2.sv
// Multi-cycle control FSM: fetch with stall watchdog, decode, one execute state
// per instruction class, HALT with resume, and a reset-only TRAP.
module controller_v2
  import ctrl_pkg::*;
#(
  parameter int OP_W      = 4,
  parameter int SEL_ALU_W = 4,
  parameter int WAIT_MAX  = 15,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 CLB,
  input  logic [OP_W-1:0]      op,
  input  logic                 z,
  input  logic                 c,
  input  logic                 mem_ready,
  input  logic                 resume,
  output logic                 fetch_req,
  output logic                 LoadIR,
  output logic                 IncPC,
  output logic                 SelPC,
  output logic                 LoadPC,
  output logic                 LoadReg,
  output logic                 LoadAcc,
  output logic [1:0]           SelAcc,
  output logic [SEL_ALU_W-1:0] SelALU,
  output logic                 halted,
  output logic                 trap,
  output logic [CNT_W-1:0]     retired
);

  localparam int TMR_W = $clog2(WAIT_MAX + 1);
  localparam logic [TMR_W-1:0] WAIT_LIM = TMR_W'(WAIT_MAX);

  state_e state, state_nxt;
  logic   retire;
  logic   wait_expired;
  logic   tmr_clear;
  logic   tmr_tick;

  logic [OP_W+3:0]      op_ext;
  logic [3:0]           opc;
  logic                 op_ok;
  logic                 is_jz;
  logic                 is_jc;
  logic                 jump_taken;
  logic [SEL_ALU_W-1:0] alu_sel;

  // Wide opcodes are legal only when every bit above the 4-bit field is zero.
  assign op_ext     = {4'b0000, op};
  assign opc        = op_ext[3:0];
  assign op_ok      = !(|op_ext[OP_W+3:4]) && op_legal(opc);
  assign is_jz      = (opc == OP_JZRS) || (opc == OP_JZIM);
  assign is_jc      = (opc == OP_JCRS) || (opc == OP_JCIM);
  assign jump_taken = (is_jz && z) || (is_jc && c);
  assign alu_sel    = SEL_ALU_W'(op);

  assign tmr_clear = (state != ST_FETCH);
  assign tmr_tick  = (state == ST_FETCH) && !mem_ready;

  fetch_timer #(.W(TMR_W)) u_fetch_timer (
    .clk     (clk),
    .rst_n   (CLB),
    .clear   (tmr_clear),
    .tick    (tmr_tick),
    .limit   (WAIT_LIM),
    .expired (wait_expired)
  );

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      state   <= ST_INIT;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (retire) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    fetch_req = 1'b0;
    LoadIR    = 1'b0;
    IncPC     = 1'b0;
    SelPC     = 1'b0;
    LoadPC    = 1'b0;
    LoadReg   = 1'b0;
    LoadAcc   = 1'b0;
    SelAcc    = ACC_SRC_ALU;
    SelALU    = '0;
    halted    = 1'b0;
    trap      = 1'b0;
    case (state)
      ST_INIT: state_nxt = ST_FETCH;
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (mem_ready) begin
          LoadIR    = 1'b1;
          IncPC     = 1'b1;
          state_nxt = ST_DECODE;
        end else if (wait_expired) begin
          state_nxt = ST_TRAP;
        end
      end
      ST_DECODE: begin
        if (!op_ok) begin
          state_nxt = ST_TRAP;
        end else begin
          case (opc)
            OP_ADD, OP_SUB, OP_NOR, OP_MOVR,
            OP_SHL, OP_SHR, OP_LDIM:           state_nxt = ST_EX_ACC;
            OP_MOVA:                           state_nxt = ST_EX_REG;
            OP_JZRS, OP_JZIM, OP_JCRS, OP_JCIM: state_nxt = ST_EX_PC;
            OP_HALT:                           state_nxt = ST_HALT;
            OP_NOP: begin
              state_nxt = ST_FETCH;
              retire    = 1'b1;
            end
            default:                           state_nxt = ST_TRAP;
          endcase
        end
      end
      ST_EX_ACC: begin
        LoadAcc   = 1'b1;
        SelALU    = alu_sel;
        if (opc == OP_MOVR)      SelAcc = ACC_SRC_REG;
        else if (opc == OP_LDIM) SelAcc = ACC_SRC_IMM;
        state_nxt = ST_FETCH;
        retire    = 1'b1;
      end
      ST_EX_REG: begin
        LoadReg   = 1'b1;
        state_nxt = ST_FETCH;
        retire    = 1'b1;
      end
      ST_EX_PC: begin
        if (jump_taken) begin
          LoadPC = 1'b1;
          SelPC  = (opc == OP_JZRS) || (opc == OP_JCRS);
        end
        state_nxt = ST_FETCH;
        retire    = 1'b1;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (resume) begin
          state_nxt = ST_FETCH;
          retire    = 1'b1;
        end
      end
      ST_TRAP: begin
        halted = 1'b1;
        trap   = 1'b1;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_controller_v2.sv
// Directed bench for controller_v2: instruction classes, jumps, fetch watchdog,
// HALT/resume, illegal opcode trap, async reset mid-instruction and counter wrap.
module tb_controller_v2;

  logic       clk = 1'b0;
  logic       CLB;
  logic [3:0] op;
  logic       z, c, mem_ready, resume;
  logic       fetch_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0] SelAcc;
  logic [3:0] SelALU;
  logic       halted, trap;
  logic [3:0] retired;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] exp_ret = '0;

  always #5 clk = ~clk;

  controller_v2 #(.OP_W(4), .SEL_ALU_W(4), .WAIT_MAX(15), .CNT_W(4)) dut (
    .clk       (clk),
    .CLB       (CLB),
    .op        (op),
    .z         (z),
    .c         (c),
    .mem_ready (mem_ready),
    .resume    (resume),
    .fetch_req (fetch_req),
    .LoadIR    (LoadIR),
    .IncPC     (IncPC),
    .SelPC     (SelPC),
    .LoadPC    (LoadPC),
    .LoadReg   (LoadReg),
    .LoadAcc   (LoadAcc),
    .SelAcc    (SelAcc),
    .SelALU    (SelALU),
    .halted    (halted),
    .trap      (trap),
    .retired   (retired)
  );

  // {fetch_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU, halted, trap}
  logic [14:0] outs;
  assign outs = {fetch_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
                 SelAcc, SelALU, halted, trap};

  localparam logic [14:0] O_IDLE   = 15'b000_0000_00_0000_00;
  localparam logic [14:0] O_FETCH  = 15'b111_0000_00_0000_00;
  localparam logic [14:0] O_FETCHW = 15'b100_0000_00_0000_00;
  localparam logic [14:0] O_HALT   = 15'b000_0000_00_0000_10;
  localparam logic [14:0] O_TRAP   = 15'b000_0000_00_0000_11;

  function automatic logic [14:0] ov(input logic spc, lpc, lreg, lacc,
                                     input logic [1:0] sacc, input logic [3:0] salu);
    return {3'b000, spc, lpc, lreg, lacc, sacc, salu, 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Starts with the DUT in FETCH; ends one cycle after the execute state.
  task automatic run_ex(input string t, input logic [3:0] o, input logic zz, cc,
                        input logic [14:0] ex);
    op = o; z = zz; c = cc; mem_ready = 1'b1;
    #1 chk({t, "_fetch"}, 32'(outs), 32'(O_FETCH));
    nxt(); #1 chk({t, "_dec"}, 32'(outs), 32'(O_IDLE));
    nxt(); #1 chk({t, "_ex"}, 32'(outs), 32'(ex));
    nxt(); exp_ret++;
    #1 chk({t, "_ret"}, 32'(retired), 32'(exp_ret));
  endtask

  task automatic run_nop();
    op = 4'b0000; mem_ready = 1'b1;
    #1 chk("nop_fetch", 32'(outs), 32'(O_FETCH));
    nxt(); #1 chk("nop_dec", 32'(outs), 32'(O_IDLE));
    nxt(); exp_ret++;
    #1 chk("nop_ret", 32'(retired), 32'(exp_ret));
  endtask

  // Asserts reset immediately, checks the async clear, then releases and lands in FETCH.
  task automatic do_reset();
    CLB = 1'b0;
    #1 chk("rst_out", 32'(outs), 32'(O_IDLE));
    chk("rst_ret", 32'(retired), 32'd0);
    exp_ret = '0;
    nxt(); nxt();
    CLB = 1'b1;
    #1 chk("init_out", 32'(outs), 32'(O_IDLE));
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    CLB = 1'b0; op = '0; z = 1'b0; c = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    nxt();
    do_reset();

    run_ex("add",  4'b0001, 0, 0, ov(0, 0, 0, 1, 2'b00, 4'b0001));
    run_ex("sub",  4'b0010, 0, 0, ov(0, 0, 0, 1, 2'b00, 4'b0010));
    run_ex("nor",  4'b0011, 0, 0, ov(0, 0, 0, 1, 2'b00, 4'b0011));
    run_ex("movr", 4'b0100, 0, 0, ov(0, 0, 0, 1, 2'b10, 4'b0100));
    run_ex("shl",  4'b1011, 0, 0, ov(0, 0, 0, 1, 2'b00, 4'b1011));
    run_ex("shr",  4'b1100, 0, 0, ov(0, 0, 0, 1, 2'b00, 4'b1100));
    run_ex("ldim", 4'b1101, 0, 0, ov(0, 0, 0, 1, 2'b11, 4'b1101));
    run_ex("mova", 4'b0101, 0, 0, ov(0, 0, 1, 0, 2'b00, 4'b0000));
    run_ex("jzim_nt", 4'b0111, 0, 1, O_IDLE);
    run_ex("jzim_t",  4'b0111, 1, 0, ov(0, 1, 0, 0, 2'b00, 4'b0000));
    run_ex("jcrs_t",  4'b1000, 0, 1, ov(1, 1, 0, 0, 2'b00, 4'b0000));
    run_ex("jzrs_t",  4'b0110, 1, 0, ov(1, 1, 0, 0, 2'b00, 4'b0000));
    run_ex("jcim_nt", 4'b1010, 1, 0, O_IDLE);
    run_ex("jcim_t",  4'b1010, 0, 1, ov(0, 1, 0, 0, 2'b00, 4'b0000));
    run_ex("jzrs_nt", 4'b0110, 0, 1, O_IDLE);
    run_nop();

    // HALT holds for ten cycles, then one resume pulse retires it
    op = 4'b1111; mem_ready = 1'b1;
    #1 chk("halt_fetch", 32'(outs), 32'(O_FETCH));
    nxt(); #1 chk("halt_dec", 32'(outs), 32'(O_IDLE));
    nxt();
    for (int i = 0; i < 10; i++) begin
      #1 chk("halt_hold", 32'(outs), 32'(O_HALT));
      chk("halt_ret", 32'(retired), 32'(exp_ret));
      nxt();
    end
    resume = 1'b1; op = 4'b0000;
    #1 chk("halt_res", 32'(outs), 32'(O_HALT));
    nxt(); resume = 1'b0; exp_ret++;
    #1 chk("halt_back", 32'(outs), 32'(O_FETCH));
    chk("halt_retired", 32'(retired), 32'(exp_ret));

    // WAIT_MAX-1 stall cycles never trap; done twice to show the counter restarts
    for (int k = 0; k < 2; k++) begin
      op = 4'b0000; mem_ready = 1'b0;
      for (int i = 0; i < 14; i++) begin
        #1 chk("wait_short", 32'(outs), 32'(O_FETCHW));
        nxt();
      end
      mem_ready = 1'b1;
      #1 chk("wait_load", 32'(outs), 32'(O_FETCH));
      nxt(); #1 chk("wait_dec", 32'(outs), 32'(O_IDLE));
      nxt(); exp_ret++;
      #1 chk("wait_notrap", 32'(trap), 32'd0);
      chk("wait_ret", 32'(retired), 32'(exp_ret));
    end

    // Illegal opcode goes straight from DECODE to TRAP
    op = 4'b1001; mem_ready = 1'b1;
    #1 chk("ill_fetch", 32'(outs), 32'(O_FETCH));
    nxt(); #1 chk("ill_dec", 32'(outs), 32'(O_IDLE));
    nxt(); #1 chk("ill_trap", 32'(outs), 32'(O_TRAP));
    resume = 1'b1; nxt(); resume = 1'b0; nxt();
    #1 chk("ill_stay", 32'(outs), 32'(O_TRAP));
    chk("ill_ret", 32'(retired), 32'(exp_ret));

    do_reset();
    run_ex("add2", 4'b0001, 0, 0, ov(0, 0, 0, 1, 2'b00, 4'b0001));
    op = 4'b0001; mem_ready = 1'b1;
    nxt(); nxt();
    #1 chk("mid_ex", 32'(outs), 32'(ov(0, 0, 0, 1, 2'b00, 4'b0001)));
    chk("mid_ret", 32'(retired), 32'd1);
    do_reset();

    // Retired counter wraps from 15 to 0
    for (int i = 0; i < 15; i++) run_nop();
    chk("wrap15", 32'(retired), 32'd15);
    run_nop();
    chk("wrap0", 32'(retired), 32'd0);

    // WAIT_MAX stall cycles trap; resume cannot leave TRAP
    op = 4'b0000; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1 chk("wait_long", 32'(outs), 32'(O_FETCHW));
      nxt();
    end
    #1 chk("wait_trap", 32'(outs), 32'(O_TRAP));
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      resume = 1'b1; nxt(); resume = 1'b0; nxt();
      #1 chk("trap_stay", 32'(outs), 32'(O_TRAP));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/controller_v2.md
CONTROLLER_V2 -- requirements
Module: controller_v2

Interface
REQ-001 Parameter OP_W, default 4: opcode width; opcodes wider than 4 bits are zero-extended for decode, and any nonzero upper bit makes the opcode illegal.
REQ-002 Parameter SEL_ALU_W, default 4: SelALU width.
REQ-003 Parameter WAIT_MAX, default 15: maximum number of consecutive FETCH cycles with mem_ready=0 before a trap is taken.
REQ-004 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  the single clock, rising edge.
- CLB  in  1  reset; asynchronous, active-low.
- op  in  OP_W  opcode from the IR.
- z  in  1  ACC zero flag.
- c  in  1  carry flag.
- mem_ready  in  1  instruction memory data valid.
- resume  in  1  leave HALT.
- fetch_req  out  1  instruction fetch request.
- LoadIR  out  1  IR write enable.
- IncPC  out  1  PC increment enable.
- SelPC  out  1  PC source: 1 = register, 0 = immediate.
- LoadPC  out  1  PC write enable.
- LoadReg  out  1  register write enable.
- LoadAcc  out  1  ACC write enable.
- SelAcc  out  2  ACC source: 00 = ALU, 10 = register, 11 = immediate.
- SelALU  out  SEL_ALU_W  ALU operation select.
- halted  out  1  core halted.
- trap  out  1  sticky fault flag.
- retired  out  CNT_W  count of completed instructions.

Function
REQ-006 Opcodes: NOP 0000, ADD 0001, SUB 0010, NOR 0011, MOVR 0100, MOVA 0101, JZRS 0110, JZIM 0111, JCRS 1000, JCIM 1010, SHL 1011, SHR 1100, LDIM 1101, HALT 1111. The codes 1001 and 1110 are illegal.
REQ-007 States: INIT, FETCH, DECODE, EX_PC, EX_ACC, EX_REG, HALT, TRAP. Every unlisted encoding goes to INIT on the next clock.
REQ-008 INIT goes to FETCH after one cycle. All outputs are 0 in INIT.
REQ-009 FETCH: fetch_req=1. When mem_ready=1: LoadIR=1 and IncPC=1 in the same cycle, then go to DECODE. When mem_ready=0: stay in FETCH and increment the wait counter.
REQ-010 The wait counter clears on every entry to FETCH. When the counter reaches WAIT_MAX with mem_ready still 0, go to TRAP.
REQ-011 DECODE: all load enables are 0. Next state by opcode:
- ADD, SUB, NOR, MOVR, SHL, SHR, LDIM go to EX_ACC.
- MOVA goes to EX_REG.
- JZRS, JZIM, JCRS, JCIM go to EX_PC.
- NOP goes to FETCH.
- HALT goes to HALT.
- Illegal opcodes go to TRAP.
REQ-012 EX_ACC: LoadAcc=1 and SelALU=op (zero-extended or truncated to SEL_ALU_W). SelAcc=10 for MOVR, 11 for LDIM, 00 otherwise. Next state FETCH.
REQ-013 EX_REG: LoadReg=1, next state FETCH.
REQ-014 EX_PC: the jump is taken when (JZ* and z=1) or (JC* and c=1), using the flags sampled in this cycle.
- Taken: LoadPC=1; SelPC=1 for JZRS/JCRS and 0 for JZIM/JCIM.
- Not taken: LoadPC=0.
- Next state FETCH in both cases.
REQ-015 Every output not explicitly asserted in a state is 0 in that state. All outputs are driven from the state register plus op, z, c and mem_ready, with no latches.
REQ-016 retired increments by 1 on each exit from EX_ACC, EX_REG, EX_PC, and on each exit from DECODE for NOP. It wraps from all-ones to 0.
REQ-017 HALT: halted=1. The block stays in HALT until resume=1, then goes to FETCH and counts HALT as retired. resume is ignored in every other state.
REQ-018 TRAP: trap=1 and halted=1. The only exit from TRAP is reset; resume has no effect.
REQ-019 Instruction latency: 3 cycles for ALU, register and jump instructions, and 2 cycles for NOP, in each case with mem_ready already 1 at FETCH.

Reset
REQ-020 While CLB=0, and asynchronously on its assertion: state=INIT, wait counter=0, retired=0, trap=0, and all outputs are 0. This applies at any point, including mid-wait and mid-instruction.
REQ-021 The first FETCH occurs in the second rising edge's cycle after CLB deasserts.

Structure
REQ-022 Opcode and state-encoding constants belong in the shared package ctrl_pkg, which the datapath also uses.
REQ-023 The wait counter is a sub-module, fetch_timer, with inputs clear, tick and limit and an expired output. Everything else is one module.

Verification
REQ-024 ADD from reset with mem_ready=1: FETCH(LoadIR=1, IncPC=1), then DECODE, then EX_ACC(LoadAcc=1, SelAcc=00, SelALU=0001). retired goes to 1.
REQ-025 JZIM with z=0: EX_PC has LoadPC=0. JZIM with z=1: LoadPC=1, SelPC=0. JCRS with c=1: LoadPC=1, SelPC=1.
REQ-026 mem_ready held 0 for WAIT_MAX-1 cycles, then 1: LoadIR pulses and there is no trap. Held 0 for WAIT_MAX cycles: trap=1, and the block stays trapped through resume pulses.
REQ-027 HALT: halted=1 for 10 cycles; a resume pulse returns the block to FETCH; retired increments by 1.
REQ-028 Illegal opcode 1001: TRAP follows DECODE. CLB pulsed low mid-EX_ACC: all outputs 0 immediately, and retired=0.
REQ-029 With CNT_W=4, 16 NOPs: retired wraps 15 to 0.
